// File: rtl/alu_arbiter.sv
// alu_arbiter: shares one combinational ALU between two clients.
//
// A winner is picked in IDLE and its operands are latched on the request
// handshake. The ALU is evaluated from those registers in EXEC, the result
// is captured, and it is held on the winner's response channel in RESP until
// that client takes it.
//
// Build option: ALU_ARB_RR_EN
//   defined   -> round-robin on contention (the client that was not granted last wins)
//   undefined -> fixed priority (client 0 wins contention)
//
// Ports
//   clk, rst                 clock, synchronous active-high reset
//   req_valid_i/req_ready_o  per-client request handshake (bit i = client i)
//   req_op1_i/req_op2_i      per-client operands, client i at [i*DWIDTH +: DWIDTH]
//   req_sel_i                per-client ALU select, client i at [i*2 +: 2]
//   rsp_valid_o/rsp_ready_i  per-client response handshake
//   rsp_res_o                shared result bus, meaningful where rsp_valid_o is set
//   alu_op1_o/alu_op2_o/alu_sel_o  to the shared ALU (held at latched values)
//   alu_res_i                from the shared ALU
//   busy_o                   FSM not in IDLE
//   op_cnt_o                 completed responses, wraps
module alu_arbiter #(
    parameter int DWIDTH = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [1:0]          req_valid_i,
    output logic [1:0]          req_ready_o,
    input  logic [2*DWIDTH-1:0] req_op1_i,
    input  logic [2*DWIDTH-1:0] req_op2_i,
    input  logic [3:0]          req_sel_i,
    output logic [1:0]          rsp_valid_o,
    input  logic [1:0]          rsp_ready_i,
    output logic [DWIDTH-1:0]   rsp_res_o,
    output logic [DWIDTH-1:0]   alu_op1_o,
    output logic [DWIDTH-1:0]   alu_op2_o,
    output logic [1:0]          alu_sel_o,
    input  logic [DWIDTH-1:0]   alu_res_i,
    output logic                busy_o,
    output logic [DWIDTH-1:0]   op_cnt_o
);

    localparam int NUM_CLI = 2;

    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    state_t                           state_q, state_d;
    logic [DWIDTH-1:0]                op1_q, op2_q, res_q, cnt_q;
    logic [1:0]                       sel_q;
    // last_grant_q doubles as the id of the request in flight: it is written
    // only on a handshake, so during EXEC/RESP it names the current client.
    logic                             last_grant_q;
    logic                             win;
    logic                             req_hs, rsp_hs;

    logic [NUM_CLI-1:0][DWIDTH-1:0]   op1_cli, op2_cli;
    logic [NUM_CLI-1:0][1:0]          sel_cli;

    for (genvar g = 0; g < NUM_CLI; g++) begin : g_cli
        assign op1_cli[g] = req_op1_i[g*DWIDTH +: DWIDTH];
        assign op2_cli[g] = req_op2_i[g*DWIDTH +: DWIDTH];
        assign sel_cli[g] = req_sel_i[g*2 +: 2];
    end

    // Winner is only meaningful when at least one valid is set.
    always_comb begin
`ifdef ALU_ARB_RR_EN
        win = (&req_valid_i) ? ~last_grant_q : ~req_valid_i[0];
`else
        win = ~req_valid_i[0];
`endif
    end

    // A ready always goes to someone when any valid is up in IDLE, so the
    // handshake reduces to "IDLE and any valid". Ready is masked during reset
    // so nothing looks accepted on a cycle that will be discarded.
    assign req_hs = (state_q == IDLE) && (|req_valid_i) && !rst;
    assign rsp_hs = (state_q == RESP) && rsp_ready_i[last_grant_q];

    always_comb begin
        state_d     = state_q;
        req_ready_o = '0;
        rsp_valid_o = '0;
        case (state_q)
            IDLE: begin
                if (req_hs) begin
                    req_ready_o[win] = 1'b1;
                    state_d          = EXEC;
                end
            end
            EXEC: state_d = RESP;
            RESP: begin
                rsp_valid_o[last_grant_q] = 1'b1;
                if (rsp_hs) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            op1_q        <= '0;
            op2_q        <= '0;
            sel_q        <= '0;
            res_q        <= '0;
            cnt_q        <= '0;
            last_grant_q <= 1'b1;   // client 0 wins the first contention
        end else begin
            state_q <= state_d;
            if (req_hs) begin
                op1_q        <= op1_cli[win];
                op2_q        <= op2_cli[win];
                sel_q        <= sel_cli[win];
                last_grant_q <= win;
            end
            if (state_q == EXEC) res_q <= alu_res_i;
            if (rsp_hs) cnt_q <= cnt_q + 1'b1;
        end
    end

    assign alu_op1_o = op1_q;
    assign alu_op2_o = op2_q;
    assign alu_sel_o = sel_q;
    assign rsp_res_o = res_q;
    assign busy_o    = (state_q != IDLE);
    assign op_cnt_o  = cnt_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: a behavioural model of the arbiter (one operation in
// flight, accept -> response two cycles later) with a scoreboard queue of
// expected responses, a bench ALU, directed scenarios and a random phase.
module tb_alu_arbiter;
    localparam int DW = 32;

    logic            clk = 1'b0;
    logic            rst;
    logic [1:0]      req_valid_i, req_ready_o, rsp_valid_o, rsp_ready_i;
    logic [2*DW-1:0] req_op1_i, req_op2_i;
    logic [3:0]      req_sel_i;
    logic [DW-1:0]   rsp_res_o, alu_op1_o, alu_op2_o, alu_res_i, op_cnt_o;
    logic [1:0]      alu_sel_o;
    logic            busy_o;

    alu_arbiter #(.DWIDTH(DW)) dut (
        .clk(clk), .rst(rst),
        .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
        .req_op1_i(req_op1_i), .req_op2_i(req_op2_i), .req_sel_i(req_sel_i),
        .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i), .rsp_res_o(rsp_res_o),
        .alu_op1_o(alu_op1_o), .alu_op2_o(alu_op2_o), .alu_sel_o(alu_sel_o),
        .alu_res_i(alu_res_i), .busy_o(busy_o), .op_cnt_o(op_cnt_o)
    );

    always #5 clk = ~clk;

    // Bench ALU: 00 add, 01 sub, 10 and, 11 xor.
    function automatic logic [DW-1:0] alu_ref(input logic [DW-1:0] a, input logic [DW-1:0] b,
                                              input logic [1:0] s);
        case (s)
            2'd0:    return a + b;
            2'd1:    return a - b;
            2'd2:    return a & b;
            default: return a ^ b;
        endcase
    endfunction

    assign alu_res_i = alu_ref(alu_op1_o, alu_op2_o, alu_sel_o);

    function automatic bit ref_win(input logic [1:0] v, input bit last);
        if (v == 2'b11) begin
`ifdef ALU_ARB_RR_EN
            return ~last;
`else
            return 1'b0;
`endif
        end
        return v[1] & ~v[0];
    endfunction

    typedef struct {
        bit            cl;
        logic [DW-1:0] op1, op2, res;
        logic [1:0]    sel;
        int            acc_cyc;
    } exp_t;

    exp_t          sbq[$];
    int            vectors = 0, miscompares = 0;
    int            cyc = 0;
    int            freed_cyc = -1;
    logic [1:0]    acc = 2'b00;
    bit            m_last = 1'b1;
    logic [DW-1:0] m_cnt = '0;
    bit            prev_rst = 1'b0;
    int            grant_log[$];
    int            acc_cyc_log[$];

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Response monitor: pops the scoreboard on each response handshake.
    always @(negedge clk) begin : monitor
        exp_t       e;
        logic [1:0] exp_rsp;
        if (rst) begin
            chk("ready_in_rst", 32'(req_ready_o), 32'd0);
            sbq.delete();
            m_cnt     = '0;
            freed_cyc = -1;
            prev_rst  = 1'b1;
        end else begin
            if (prev_rst) begin
                chk("rst_rsp_res", rsp_res_o, '0);
                chk("rst_alu_op1", alu_op1_o, '0);
                chk("rst_alu_op2", alu_op2_o, '0);
                chk("rst_alu_sel", 32'(alu_sel_o), 32'd0);
                prev_rst = 1'b0;
            end
            chk("op_cnt", op_cnt_o, m_cnt);
            chk("busy", 32'(busy_o), 32'(sbq.size() > 0));
            exp_rsp = 2'b00;
            if (sbq.size() > 0) begin
                e = sbq[0];
                if (cyc == e.acc_cyc + 1) begin
                    chk("alu_op1", alu_op1_o, e.op1);
                    chk("alu_op2", alu_op2_o, e.op2);
                    chk("alu_sel", 32'(alu_sel_o), 32'(e.sel));
                end
                if (cyc >= e.acc_cyc + 2) exp_rsp[e.cl] = 1'b1;
            end
            chk("rsp_valid", 32'(rsp_valid_o), 32'(exp_rsp));
            if (exp_rsp != 2'b00 && rsp_ready_i[e.cl]) begin
                chk("rsp_res", rsp_res_o, e.res);
                void'(sbq.pop_front());
                m_cnt     = m_cnt + 1;
                freed_cyc = cyc;
            end
        end
    end

    // Acceptance model: predicts ready, pushes the expected response.
    always @(negedge clk) begin : accept
        bit         busy, w;
        logic [1:0] exp_rdy;
        #1;
        if (rst) begin
            m_last = 1'b1;
            acc    = 2'b00;
        end else begin
            busy    = (sbq.size() > 0) || (freed_cyc == cyc);
            exp_rdy = 2'b00;
            w       = ref_win(req_valid_i, m_last);
            if (!busy && req_valid_i != 2'b00) exp_rdy[w] = 1'b1;
            chk("req_ready", 32'(req_ready_o), 32'(exp_rdy));
            acc = req_valid_i & req_ready_o;
            if (exp_rdy != 2'b00) begin
                sbq.push_back('{cl: w,
                                op1: req_op1_i[int'(w)*DW +: DW],
                                op2: req_op2_i[int'(w)*DW +: DW],
                                sel: req_sel_i[int'(w)*2 +: 2],
                                res: alu_ref(req_op1_i[int'(w)*DW +: DW],
                                             req_op2_i[int'(w)*DW +: DW],
                                             req_sel_i[int'(w)*2 +: 2]),
                                acc_cyc: cyc});
                m_last = w;
                grant_log.push_back(int'(w));
                acc_cyc_log.push_back(cyc);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic [DW-1:0] a, input logic [DW-1:0] b,
                           input logic [1:0] s);
        req_valid_i[i]       = 1'b1;
        req_op1_i[i*DW +: DW] = a;
        req_op2_i[i*DW +: DW] = b;
        req_sel_i[i*2 +: 2]   = s;
    endtask

    task automatic rand_req(input int i);
        set_req(i, $urandom, $urandom, 2'($urandom_range(0, 3)));
    endtask

    task automatic wait_idle();
        bit done = 1'b0;
        for (int k = 0; k < 50 && !done; k++) begin
            if (sbq.size() == 0) done = 1'b1;
            else step();
        end
        if (!done) begin
            vectors++;
            miscompares++;
            $display("FAIL wait_idle: response still pending after 50 cycles (cycle %0d)", cyc);
        end
    endtask

    initial begin : driver
        logic [DW-1:0] a, b, exp_res;
        logic [1:0]    s;
        int            exp_g;

        // Reset with random inputs on the pins.
        rst = 1'b1;
        repeat (2) begin
            req_valid_i = 2'($urandom);
            req_op1_i   = {$urandom, $urandom};
            req_op2_i   = {$urandom, $urandom};
            req_sel_i   = 4'($urandom);
            rsp_ready_i = 2'($urandom);
            step();
        end
        rst = 1'b0;
        req_valid_i = 2'b00;
        rsp_ready_i = 2'b00;

        // Single request: 5 + 7.
        rsp_ready_i = 2'b11;
        set_req(0, 32'd5, 32'd7, 2'b00);
        @(negedge clk); #2;
        chk("single_ready", 32'(req_ready_o), 32'd1);
        step();
        req_valid_i = 2'b00;
        @(negedge clk);
        chk("single_op1", alu_op1_o, 32'd5);
        chk("single_op2", alu_op2_o, 32'd7);
        step();
        @(negedge clk);
        chk("single_rsp_valid", 32'(rsp_valid_o), 32'd1);
        chk("single_rsp_res", rsp_res_o, 32'd12);
        step();
        @(negedge clk);
        chk("single_cnt", op_cnt_o, 32'd1);
        step();

        // Contention: both valid continuously, response always taken.
        wait_idle();
        grant_log.delete();
        acc_cyc_log.delete();
        rand_req(0);
        rand_req(1);
        repeat (12) begin
            step();
            for (int i = 0; i < 2; i++) if (acc[i]) rand_req(i);
        end
        req_valid_i = 2'b00;
        wait_idle();
        chk("cont_grants", 32'(grant_log.size()), 32'd4);
        for (int k = 0; k < 4 && k < grant_log.size(); k++) begin
`ifdef ALU_ARB_RR_EN
            exp_g = (k % 2 == 0) ? 1 : 0;   // last grant before this was client 0
`else
            exp_g = 0;
`endif
            chk("cont_grant_id", 32'(grant_log[k]), 32'(exp_g));
            if (k > 0) chk("cont_spacing", 32'(acc_cyc_log[k] - acc_cyc_log[k-1]), 32'd3);
        end
        step();
        chk("cont_cnt", op_cnt_o, 32'd5);

        // Backpressure on client 1; client 0's ready is up but must be ignored.
        rsp_ready_i = 2'b01;
        a = $urandom; b = $urandom; s = 2'b01;
        exp_res = alu_ref(a, b, s);
        set_req(1, a, b, s);
        step();
        req_valid_i[1] = 1'b0;
        rand_req(0);
        step();
        repeat (5) begin
            @(negedge clk); #2;
            chk("bp_rsp_valid", 32'(rsp_valid_o), 32'd2);
            chk("bp_rsp_res", rsp_res_o, exp_res);
            chk("bp_ready0", 32'(req_ready_o), 32'd0);
            step();
        end
        rsp_ready_i = 2'b11;
        step();
        @(negedge clk); #2;
        chk("bp_next_accept", 32'(req_ready_o), 32'd1);
        step();
        req_valid_i[0] = 1'b0;
        wait_idle();

        // Reset while in EXEC: result dropped, counter cleared.
        set_req(0, $urandom, $urandom, 2'b10);
        step();
        req_valid_i = 2'b00;
        rst = 1'b1;
        step();
        rst = 1'b0;
        @(negedge clk);
        chk("midrst_rsp_valid", 32'(rsp_valid_o), 32'd0);
        chk("midrst_cnt", op_cnt_o, 32'd0);
        chk("midrst_busy", 32'(busy_o), 32'd0);
        step();
        step();

        // Random traffic with occasional resets and response backpressure.
        repeat (3000) begin
            step();
            rst = ($urandom_range(0, 199) == 0);
            for (int i = 0; i < 2; i++) begin
                if (req_valid_i[i]) begin
                    if (acc[i]) begin
                        if ($urandom_range(0, 1) == 1) rand_req(i);
                        else req_valid_i[i] = 1'b0;
                    end
                end else if ($urandom_range(0, 2) == 0) begin
                    rand_req(i);
                end
            end
            rsp_ready_i = 2'($urandom);
        end
        rst = 1'b0;
        req_valid_i = 2'b00;
        rsp_ready_i = 2'b11;
        repeat (10) step();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
